// File: rtl/mux_pkg.sv
// Shared types and limits for the N-source skid-buffered channel mux.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    localparam int unsigned SRC_MIN = 2;
    localparam int unsigned SRC_MAX = 16;
    localparam int unsigned CH_MIN  = 1;

    // Select width for n sources, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muxn_sel.sv
// Combinational source select: all channels of src[sel], or zeros plus error flag when sel is out of range.
module muxn_sel
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned CH    = 2,
    parameter  int unsigned SRC   = 3,
    localparam int unsigned SELW  = sel_width(SRC)
) (
    input  logic [SRC-1:0][CH-1:0][WIDTH-1:0] src_i,
    input  logic [SELW-1:0]                   sel_i,
    output logic [CH-1:0][WIDTH-1:0]          data_c,
    output logic                              err_c
);

    // Compare-and-pick loop keeps out-of-range codes from indexing past src.
    always_comb begin
        data_c = '0;
        err_c  = 1'b1;
        for (int unsigned s = 0; s < SRC; s++) begin
            if (sel_i == SELW'(s)) begin
                data_c = src_i[s];
                err_c  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/muxn_skid.sv
// Source-select mux with a two-entry (main + skid) output buffer; in_ready is registered.
module muxn_skid
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned CH    = 2,
    parameter  int unsigned SRC   = 3,
    localparam int unsigned SELW  = sel_width(SRC)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SRC-1:0][CH-1:0][WIDTH-1:0] src,
    input  logic [SELW-1:0]                   sel,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CH-1:0][WIDTH-1:0]          out,
    output logic                              sel_err
);

    logic [CH-1:0][WIDTH-1:0] sel_data_c;
    logic                     sel_err_c;

    muxn_sel #(
        .WIDTH (WIDTH),
        .CH    (CH),
        .SRC   (SRC)
    ) u_sel (
        .src_i  (src),
        .sel_i  (sel),
        .data_c (sel_data_c),
        .err_c  (sel_err_c)
    );

    buf_state_e               state_q, state_d;
    logic [CH-1:0][WIDTH-1:0] main_data_q, skid_data_q;
    logic                     main_err_q, skid_err_q;
    logic                     in_ready_q, out_valid_q;

    logic accept_c, xfer_c;
    logic load_main_c, load_skid_c, promote_c;

    assign accept_c = in_valid && in_ready_q;
    assign xfer_c   = out_valid_q && out_ready;

    // Next state and which buffer entry is written this cycle.
    always_comb begin
        state_d     = state_q;
        load_main_c = 1'b0;
        load_skid_c = 1'b0;
        promote_c   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    load_main_c = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c && xfer_c) begin
                    load_main_c = 1'b1;
                end else if (accept_c) begin
                    load_skid_c = 1'b1;
                    state_d     = ST_FULL;
                end else if (xfer_c) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_c) begin
                    promote_c = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            if (load_main_c) begin
                main_data_q <= sel_data_c;
                main_err_q  <= sel_err_c;
            end else if (promote_c) begin
                main_data_q <= skid_data_q;
                main_err_q  <= skid_err_q;
            end
            if (load_skid_c) begin
                skid_data_q <= sel_data_c;
                skid_err_q  <= sel_err_c;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = main_data_q;
    assign sel_err   = main_err_q;

endmodule

// File: doc/muxn_skid.md
MUXN_SKID -- requirements
Module: muxn_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit width of each channel datum.
REQ-002 SHALL have parameter CH, default 2, number of parallel channels switched by one select.
REQ-003 SHALL have parameter SRC, default 3, number of selectable sources (legal range 2..16).
REQ-004 SHALL have localparam SELW = $clog2(SRC), select width (minimum 1).
REQ-005 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: in_valid  input  1  upstream beat present.
REQ-008 SHALL have port: in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port: src  input  [SRC][CH][WIDTH]  source data, src[s][c] is channel c of source s.
REQ-010 SHALL have port: sel  input  SELW  source index, sampled with the beat.
REQ-011 SHALL have port: out_valid  output  1  downstream beat present.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts the beat.
REQ-013 SHALL have port: out  output  [CH][WIDTH]  selected data, all channels from one source.
REQ-014 SHALL have port: sel_err  output  1  current out beat came from an out-of-range sel.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready; SHALL transfer out when out_valid && out_ready.
REQ-016 SHALL compute out[c] = src[sel][c] for every channel c at acceptance, captured with sel_err = 0.
REQ-017 SHALL, when sel >= SRC, capture out = all zeros and sel_err = 1 for that beat, and never stall on it.
REQ-018 SHALL present an accepted beat on out one cycle after acceptance (latency 1) when the output stage is free.
REQ-019 SHALL hold a two-entry buffer (main, skid) controlled by state EMPTY, ONE, FULL.
REQ-020 SHALL transition EMPTY->ONE on accept; ONE->EMPTY on transfer without accept; ONE->ONE on simultaneous accept and transfer; ONE->FULL on accept without transfer (beat into skid); FULL->ONE on transfer (skid moves to main).
REQ-021 SHALL drive in_ready from a register: 1 in EMPTY and ONE, 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-022 SHALL drive out_valid = 1 in ONE and FULL, 0 in EMPTY; out and sel_err SHALL come from the main entry only.
REQ-023 SHALL keep out and sel_err stable while out_valid && !out_ready.
REQ-024 SHALL preserve beat order; no beat is dropped or duplicated under any in_valid/out_ready pattern.
REQ-025 SHALL ignore src and sel when in_valid is 0 or in_ready is 0.

Reset
REQ-026 SHALL, on a clock edge with reset high, enter EMPTY: out_valid = 0, in_ready = 1, out = 0, sel_err = 0, skid contents = 0.
REQ-027 SHALL discard any buffered beats when reset is asserted mid-operation; no beat accepted in the reset cycle survives.
REQ-028 SHALL hold the reset values for every cycle reset stays high, regardless of in_valid/out_ready.

Structure
REQ-029 SHALL take the state enum (EMPTY, ONE, FULL) from shared package mux_pkg, which also holds the SRC/CH range limits.
REQ-030 SHALL put the combinational source select (src, sel -> data, err) in one sub-module muxn_sel, parametrised by WIDTH, CH, SRC.
REQ-031 SHALL use only synchronous reset and a single clk domain; no latches.

Verification
REQ-032 SHALL cover: reset, WIDTH=32 CH=2 SRC=3, in_valid=1 sel=1 src[1]={0xA5A5A5A5,0x5A5A5A5A}, out_ready=1 -> out equals that pair one cycle later, out_valid=1, sel_err=0.
REQ-033 SHALL cover: sel=3 (out of range) with in_valid=1 -> out={0,0}, sel_err=1 for exactly that beat, following beat sel=0 -> sel_err=0.
REQ-034 SHALL cover: out_ready=0, three back-to-back beats 1,2,3 -> in_ready=0 after beat 2, beat 3 held upstream; out_ready=1 -> out sequence 1,2,3 in order.
REQ-035 SHALL cover: continuous in_valid=1 and out_ready=1 for 100 cycles with incrementing data -> one beat per cycle, state stays ONE, in_ready stays 1.
REQ-036 SHALL cover: reset asserted in FULL -> next cycle out_valid=0, in_ready=1, out=0; buffered beats never appear.
REQ-037 SHALL cover: random in_valid/out_ready over 10000 cycles with scoreboard -> zero loss, zero duplication, out stable while stalled.
